// File: rtl/byte_unstriping_cond.sv
`default_nettype none
// ============================================================================
//  Module   : byte_unstriping_cond
//  Purpose  : Two-lane byte unstriper. Each lane has its own FIFO to absorb
//             inter-lane skew. Bytes are read strictly in the order lane 0,
//             lane 1, lane 0, ... and sent out as one registered byte stream.
//  Options  : UNSTRIPE_SKEW_CHK_EN - enables the sticky skew_err checker.
//             When it is undefined, skew_err is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_unstriping_cond #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] lane_0,
    input  logic                  valid_0,
    input  logic [DATA_WIDTH-1:0] lane_1,
    input  logic                  valid_1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  overflow,
    output logic                  idle,
    output logic                  skew_err
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    // Per-lane FIFO state, indexed by lane number
    logic [DATA_WIDTH-1:0] r_mem [2][DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr [2];
    logic [c_PTR_W-1:0]    r_rd_ptr [2];
    logic [c_CNT_W-1:0]    r_count [2];

    logic                  r_sel;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] w_lane_data [2];
    logic [1:0]            w_lane_valid;
    logic [1:0]            w_pop;
    logic [1:0]            w_push;
    logic [1:0]            w_drop;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_lane_data[0] = lane_0;
    assign w_lane_data[1] = lane_1;
    assign w_lane_valid   = {valid_1, valid_0};

    // Pop only the selected lane; a full FIFO still accepts when popped the same edge
    always_comb begin
        w_pop  = 2'b00;
        w_push = 2'b00;
        w_drop = 2'b00;
        for (int l = 0; l < 2; l++) begin
            w_pop[l]  = (r_sel == 1'(l)) && (r_count[l] != '0);
            w_push[l] = w_lane_valid[l] && ((r_count[l] != c_FULL) || w_pop[l]);
            w_drop[l] = w_lane_valid[l] && !w_push[l];
        end
    end

    assign w_head = r_mem[r_sel][r_rd_ptr[r_sel]];

    // FIFO storage write; contents are don't-care until counted valid
    always_ff @(posedge clk_2f) begin
        for (int l = 0; l < 2; l++) begin
            if (w_push[l]) begin
                r_mem[l][r_wr_ptr[l]] <= w_lane_data[l];
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_2f) begin
        for (int l = 0; l < 2; l++) begin
            if (!reset) begin
                r_wr_ptr[l] <= '0;
                r_rd_ptr[l] <= '0;
                r_count[l]  <= '0;
            end else begin
                if (w_push[l]) begin
                    r_wr_ptr[l] <= r_wr_ptr[l] + c_PTR_W'(1);
                end
                if (w_pop[l]) begin
                    r_rd_ptr[l] <= r_rd_ptr[l] + c_PTR_W'(1);
                end
                if (w_push[l] && !w_pop[l]) begin
                    r_count[l] <= r_count[l] + c_CNT_W'(1);
                end else if (!w_push[l] && w_pop[l]) begin
                    r_count[l] <= r_count[l] - c_CNT_W'(1);
                end
            end
        end
    end

    // Output register, lane selector and sticky overflow flag
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_sel       <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_pop != 2'b00) begin
                r_data_out  <= w_head;
                r_valid_out <= 1'b1;
                r_sel       <= ~r_sel;
            end else begin
                r_valid_out <= 1'b0;
            end
            if (w_drop != 2'b00) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef UNSTRIPE_SKEW_CHK_EN
    localparam logic [c_CNT_W-1:0] c_SKEW_LIM = c_CNT_W'(DEPTH - 1);

    logic r_skew_err;
    logic w_skew_hit;

    assign w_skew_hit = (r_count[r_sel] == '0) && (r_count[~r_sel] >= c_SKEW_LIM);

    // Sticky flag: the selected lane is starved while the other is nearly full
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            r_skew_err <= 1'b0;
        end else if (w_skew_hit) begin
            r_skew_err <= 1'b1;
        end
    end

    assign skew_err = r_skew_err;
`else
    assign skew_err = 1'b0;
`endif

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign overflow  = r_overflow;
    assign idle      = (r_count[0] == '0) && (r_count[1] == '0);

endmodule
`default_nettype wire
